// File: rtl/mips_pkg.sv
// Shared constants for the 5-stage MIPS pipeline: widths, reset PC, NOP encoding.
package mips_pkg;

   localparam int ADDR_W = 32;
   localparam int INSTR_W = 32;
   localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
   localparam logic [31:0] RESET_PC = 32'h0000_0000;
   localparam int PC_INC = 4;

endpackage

// File: rtl/if_id_reg.sv
// Pipeline register with hold > flush > bubble > load priority; used for IF/ID
// and reusable for the later pipeline registers that share the pattern.
module if_id_reg #(
   parameter int ADDR_W = mips_pkg::ADDR_W,
   parameter int INSTR_W = mips_pkg::INSTR_W
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               stall_i,
   input  logic               flush_i,
   input  logic               bubble_i,
   input  logic [INSTR_W-1:0] instr_i,
   input  logic [ADDR_W-1:0]  pcPlus4_i,
   output logic [INSTR_W-1:0] instr_o,
   output logic [ADDR_W-1:0]  pcPlus4_o,
   output logic               valid_o
);
   import mips_pkg::*;

   logic [INSTR_W-1:0] instr_q;
   logic [ADDR_W-1:0]  pcPlus4_q;
   logic               valid_q;

   // A bubble keeps the old pc_plus4 so only a redirect or reset clears it.
   always_ff @(posedge clk) begin
      if (rst) begin
         instr_q   <= INSTR_W'(NOP_INSTR);
         pcPlus4_q <= '0;
         valid_q   <= 1'b0;
      end else if (stall_i) begin
         instr_q   <= instr_q;
         pcPlus4_q <= pcPlus4_q;
         valid_q   <= valid_q;
      end else if (flush_i) begin
         instr_q   <= INSTR_W'(NOP_INSTR);
         pcPlus4_q <= '0;
         valid_q   <= 1'b0;
      end else if (bubble_i) begin
         instr_q   <= INSTR_W'(NOP_INSTR);
         valid_q   <= 1'b0;
      end else begin
         instr_q   <= instr_i;
         pcPlus4_q <= pcPlus4_i;
         valid_q   <= 1'b1;
      end
   end

   assign instr_o   = instr_q;
   assign pcPlus4_o = pcPlus4_q;
   assign valid_o   = valid_q;

endmodule

// File: rtl/fetch_stage.sv
// MIPS IF stage: PC register, next-PC select and IF/ID register (no delay slot).
// Define FETCH_PERF_CNT_EN to add saturating fetch/stall/flush counters.
module fetch_stage #(
   parameter int ADDR_W = mips_pkg::ADDR_W,
   parameter int INSTR_W = mips_pkg::INSTR_W,
   parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(mips_pkg::RESET_PC)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               stall_F,
   input  logic               stall_D,
   input  logic               branch_taken_d,
   input  logic [ADDR_W-1:0]  branch_target_d,
   input  logic               jmp_d,
   input  logic [ADDR_W-1:0]  jump_target_d,
   input  logic               imem_ready_i,
   input  logic [INSTR_W-1:0] instr_i,
   output logic [ADDR_W-1:0]  pc_f_o,
   output logic [INSTR_W-1:0] instr_d_o,
   output logic [ADDR_W-1:0]  pc_plus4_d_o,
   output logic               valid_d_o
`ifdef FETCH_PERF_CNT_EN
   ,
   output logic [31:0]        perf_fetch_cnt_o,
   output logic [31:0]        perf_stall_cnt_o,
   output logic [31:0]        perf_flush_cnt_o
`endif
);
   import mips_pkg::*;

   logic [ADDR_W-1:0] pc_q;
   logic [ADDR_W-1:0] pc_d;
   logic [ADDR_W-1:0] pcPlus4;
   logic [ADDR_W-1:0] redirectTarget;
   logic              redirect;

   // While stalled the branch outcome may depend on unresolved operands, so ignore it.
   assign redirect       = (jmp_d | branch_taken_d) & ~stall_F;
   assign redirectTarget = (jmp_d ? jump_target_d : branch_target_d) & ~ADDR_W'(3);
   assign pcPlus4        = pc_q + ADDR_W'(PC_INC);

   always_comb begin
      pc_d = pc_q;
      if (stall_F) begin
         pc_d = pc_q;
      end else if (redirect) begin
         pc_d = redirectTarget;
      end else if (imem_ready_i) begin
         pc_d = pcPlus4;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pc_q <= RESET_PC;
      end else begin
         pc_q <= pc_d;
      end
   end

   assign pc_f_o = pc_q;

   if_id_reg #(
      .ADDR_W (ADDR_W),
      .INSTR_W(INSTR_W)
   ) u_if_id (
      .clk      (clk),
      .rst      (rst),
      .stall_i  (stall_D),
      .flush_i  (redirect),
      .bubble_i (~imem_ready_i),
      .instr_i  (instr_i),
      .pcPlus4_i(pcPlus4),
      .instr_o  (instr_d_o),
      .pcPlus4_o(pc_plus4_d_o),
      .valid_o  (valid_d_o)
   );

`ifdef FETCH_PERF_CNT_EN
   logic [31:0] fetchCnt_q;
   logic [31:0] stallCnt_q;
   logic [31:0] flushCnt_q;
   logic        fetchLoad;

   assign fetchLoad = ~stall_D & ~redirect & imem_ready_i;

   // Each counter sticks at all-ones instead of wrapping.
   always_ff @(posedge clk) begin
      if (rst) begin
         fetchCnt_q <= '0;
         stallCnt_q <= '0;
         flushCnt_q <= '0;
      end else begin
         if (fetchLoad && fetchCnt_q != 32'hFFFF_FFFF) fetchCnt_q <= fetchCnt_q + 32'd1;
         if (stall_F && stallCnt_q != 32'hFFFF_FFFF) stallCnt_q <= stallCnt_q + 32'd1;
         if (redirect && flushCnt_q != 32'hFFFF_FFFF) flushCnt_q <= flushCnt_q + 32'd1;
      end
   end

   assign perf_fetch_cnt_o = fetchCnt_q;
   assign perf_stall_cnt_o = stallCnt_q;
   assign perf_flush_cnt_o = flushCnt_q;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Directed self-checking bench for fetch_stage; imem returns pc ^ 32'hDEAD_0000.
// Counter checks are compiled in when FETCH_PERF_CNT_EN is defined.
module tb_fetch_stage;

   logic        clk = 1'b0;
   logic        rst;
   logic        stall_F;
   logic        stall_D;
   logic        branch_taken_d;
   logic [31:0] branch_target_d;
   logic        jmp_d;
   logic [31:0] jump_target_d;
   logic        imem_ready_i;
   logic [31:0] instr_i;
   logic [31:0] pc_f_o;
   logic [31:0] instr_d_o;
   logic [31:0] pc_plus4_d_o;
   logic        valid_d_o;
`ifdef FETCH_PERF_CNT_EN
   logic [31:0] perf_fetch_cnt_o;
   logic [31:0] perf_stall_cnt_o;
   logic [31:0] perf_flush_cnt_o;
`endif

   int testsRun = 0;
   int testsFailed = 0;

   always #5 clk = ~clk;

   assign instr_i = pc_f_o ^ 32'hDEAD_0000;

   fetch_stage dut (
      .clk            (clk),
      .rst            (rst),
      .stall_F        (stall_F),
      .stall_D        (stall_D),
      .branch_taken_d (branch_taken_d),
      .branch_target_d(branch_target_d),
      .jmp_d          (jmp_d),
      .jump_target_d  (jump_target_d),
      .imem_ready_i   (imem_ready_i),
      .instr_i        (instr_i),
      .pc_f_o         (pc_f_o),
      .instr_d_o      (instr_d_o),
      .pc_plus4_d_o   (pc_plus4_d_o),
      .valid_d_o      (valid_d_o)
`ifdef FETCH_PERF_CNT_EN
      ,
      .perf_fetch_cnt_o(perf_fetch_cnt_o),
      .perf_stall_cnt_o(perf_stall_cnt_o),
      .perf_flush_cnt_o(perf_flush_cnt_o)
`endif
   );

   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      testsRun++;
      if (actual !== expected) begin
         testsFailed++;
         $display("[TB] FAIL %s: got %08h, expected %08h", tag, actual, expected);
      end
   endtask

   task automatic checkState(input string tag, input logic [31:0] pc, input logic [31:0] instr,
                             input logic [31:0] pc4, input logic valid);
      checkOutput({tag, ".pc"}, pc_f_o, pc);
      checkOutput({tag, ".instr"}, instr_d_o, instr);
      checkOutput({tag, ".pc4"}, pc_plus4_d_o, pc4);
      checkOutput({tag, ".valid"}, {31'd0, valid_d_o}, {31'd0, valid});
   endtask

   // Advance one clock and settle just past the edge.
   task automatic applyStimulus();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b1;
      stall_F = 1'b0;
      stall_D = 1'b0;
      branch_taken_d = 1'b0;
      branch_target_d = '0;
      jmp_d = 1'b0;
      jump_target_d = '0;
      imem_ready_i = 1'b1;
      applyStimulus();
      checkState("reset", 32'h0, 32'h0, 32'h0, 1'b0);

      rst = 1'b0;
      applyStimulus();
      checkState("run1", 32'h4, 32'hDEAD_0000, 32'h4, 1'b1);
      applyStimulus();
      checkState("run2", 32'h8, 32'hDEAD_0004, 32'h8, 1'b1);
      applyStimulus();
      applyStimulus();
      checkOutput("run4.pc", pc_f_o, 32'h10);

      branch_taken_d = 1'b1;
      branch_target_d = 32'h0000_0103;
      applyStimulus();
      checkState("branch", 32'h100, 32'h0, 32'h0, 1'b0);
      branch_taken_d = 1'b0;
      applyStimulus();
      checkState("branchTgt", 32'h104, 32'hDEAD_0100, 32'h104, 1'b1);

      stall_F = 1'b1;
      stall_D = 1'b1;
      branch_taken_d = 1'b1;
      branch_target_d = 32'h200;
      for (int i = 0; i < 3; i++) begin
         applyStimulus();
         checkState("stall", 32'h104, 32'hDEAD_0100, 32'h104, 1'b1);
      end
      stall_F = 1'b0;
      stall_D = 1'b0;
      applyStimulus();
      checkState("stallRedir", 32'h200, 32'h0, 32'h0, 1'b0);
      branch_taken_d = 1'b0;
      applyStimulus();
      checkState("stallTgt", 32'h204, 32'hDEAD_0200, 32'h204, 1'b1);

`ifdef FETCH_PERF_CNT_EN
      checkOutput("perfFlush", perf_flush_cnt_o, 32'd2);
      checkOutput("perfStall", perf_stall_cnt_o, 32'd3);
      checkOutput("perfFetch", perf_fetch_cnt_o, 32'd6);
`endif

      jmp_d = 1'b1;
      jump_target_d = 32'h400;
      branch_taken_d = 1'b1;
      branch_target_d = 32'h200;
      applyStimulus();
      checkOutput("jmpWins.pc", pc_f_o, 32'h400);
      branch_taken_d = 1'b0;

      jump_target_d = 32'h20;
      applyStimulus();
      checkOutput("to20.pc", pc_f_o, 32'h20);
      jmp_d = 1'b0;
      imem_ready_i = 1'b0;
      for (int i = 0; i < 2; i++) begin
         applyStimulus();
         checkState("notReady", 32'h20, 32'h0, 32'h0, 1'b0);
      end
      imem_ready_i = 1'b1;
      applyStimulus();
      checkState("resume", 32'h24, 32'hDEAD_0020, 32'h24, 1'b1);

      jmp_d = 1'b1;
      jump_target_d = 32'hFFFF_FFFC;
      applyStimulus();
      checkOutput("toTop.pc", pc_f_o, 32'hFFFF_FFFC);
      jmp_d = 1'b0;
      applyStimulus();
      checkState("wrap", 32'h0, 32'h2152_FFFC, 32'h0, 1'b1);

      stall_F = 1'b1;
      applyStimulus();
      checkState("stallFonly", 32'h0, 32'hDEAD_0000, 32'h4, 1'b1);
      stall_F = 1'b0;

      rst = 1'b1;
      jmp_d = 1'b1;
      jump_target_d = 32'h80;
      applyStimulus();
      checkState("rstRedir", 32'h0, 32'h0, 32'h0, 1'b0);
`ifdef FETCH_PERF_CNT_EN
      checkOutput("perfClr", perf_flush_cnt_o, 32'd0);
`endif

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
